// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample, mid-bit and bit-end strobes
// from an integer+fraction clock divisor with carry-spread periods.
module baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEF_DIV_INT  = 651,
    parameter int DEF_DIV_FRAC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              baud_tick,
    output logic              cfg_err
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              cy;
    logic [OS_W-1:0]   os_cnt;

    logic [DIV_W:0]    last;
    logic              period_end;
    logic [FRAC_W:0]   acc_sum;
    logic              bad_div;

    // Period length is act_int + cy, so the last count is that minus one.
    assign last       = {1'b0, act_int} + {{DIV_W{1'b0}}, cy} - 1'b1;
    assign period_end = ({1'b0, cnt} == last);
    assign acc_sum    = {1'b0, acc} + {1'b0, act_frac};
    assign bad_div    = (div_int < DIV_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_int   <= DIV_W'(DEF_DIV_INT);
            act_frac  <= FRAC_W'(DEF_DIV_FRAC);
            cnt       <= '0;
            acc       <= '0;
            cy        <= 1'b0;
            os_cnt    <= '0;
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (div_load) begin
            act_int   <= bad_div ? DIV_W'(2) : div_int;
            act_frac  <= div_frac;
            cfg_err   <= bad_div;
            cnt       <= '0;
            acc       <= '0;
            cy        <= 1'b0;
            os_cnt    <= '0;
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else if (!en) begin
            cnt       <= '0;
            acc       <= '0;
            cy        <= 1'b0;
            os_cnt    <= '0;
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else begin
            os_tick   <= period_end;
            mid_tick  <= period_end && (os_cnt == OS_MID);
            baud_tick <= period_end && (os_cnt == OS_LAST);
            if (period_end) begin
                cnt         <= '0;
                {cy, acc}   <= acc_sum;
                os_cnt      <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: expected strobe edges are queued by
// the stimulus and matched by a negedge monitor.
module tb_baud_gen_frac;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        div_load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        os_tick;
    logic        mid_tick;
    logic        baud_tick;
    logic        cfg_err;

    baud_gen_frac #(
        .DIV_W(16),
        .FRAC_W(4),
        .OVERSAMPLE(4),
        .DEF_DIV_INT(651),
        .DEF_DIV_FRAC(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .div_load(div_load),
        .div_int(div_int),
        .div_frac(div_frac),
        .os_tick(os_tick),
        .mid_tick(mid_tick),
        .baud_tick(baud_tick),
        .cfg_err(cfg_err)
    );

    typedef struct {
        int e;
        bit m;
        bit b;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_edge = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input int e, input bit m, input bit b);
        exp_t x;
        x.e = e;
        x.m = m;
        x.b = b;
        q.push_back(x);
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic load(input int a, input int f, input bit e,
                        output int lp);
        div_load = 1'b1;
        div_int  = 16'(a);
        div_frac = 4'(f);
        en       = e;
        lp       = cyc + 1;
        @(negedge clk);
        div_load = 1'b0;
        div_int  = 16'hdead;
        div_frac = 4'hf;
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (os_tick) begin
                last_edge = cyc;
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_tick: got tick at %0d expected none",
                             cyc);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    if (x.e != cyc || x.m != mid_tick || x.b != baud_tick) begin
                        n_fail++;
                        $display("FAIL tick: got edge %0d mid %0b baud %0b expected edge %0d mid %0b baud %0b",
                                 cyc, mid_tick, baud_tick, x.e, x.m, x.b);
                    end
                end
            end else if (mid_tick || baud_tick) begin
                n_tests++;
                n_fail++;
                $display("FAIL lone_strobe: got mid %0b baud %0b expected 0 0 at %0d",
                         mid_tick, baud_tick, cyc);
            end
        end
    end

    initial begin
        int lp;
        int t;
        int t_first;
        int r;
        rst_n    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_int  = '0;
        div_frac = '0;
        repeat (3) @(negedge clk);
        chk("rst_os", int'(os_tick), 0);
        chk("rst_mid", int'(mid_tick), 0);
        chk("rst_baud", int'(baud_tick), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Integer divisor 4, oversample 4
        load(4, 0, 1'b1, lp);
        chk("int4_cfg_err", int'(cfg_err), 0);
        for (int k = 1; k <= 8; k++)
            push(lp + 4 * k, ((k - 1) % 4) == 1, ((k - 1) % 4) == 3);
        wait_until(lp + 33);
        en = 1'b0;
        wait_until(lp + 40);
        chk("int4_drain", q.size(), 0);

        // Fractional divisor 4 + 8/16
        load(4, 8, 1'b1, lp);
        t = lp + 4;
        for (int j = 1; j <= 33; j++) begin
            push(t, ((j - 1) % 4) == 1, ((j - 1) % 4) == 3);
            t += (j % 2 == 1) ? 4 : 5;
        end
        wait_until(lp + 5);
        t_first = last_edge;
        wait_until(lp + 4 + 144 + 1);
        chk("frac_span", last_edge - t_first, 144);
        en = 1'b0;
        wait_until(lp + 160);
        chk("frac_drain", q.size(), 0);

        // Reload coincident with a period end drops that tick
        load(6, 0, 1'b1, lp);
        push(lp + 6, 1'b0, 1'b0);
        wait_until(lp + 11);
        load(3, 0, 1'b1, r);
        chk("reload_edge", r, lp + 12);
        for (int k = 1; k <= 4; k++)
            push(r + 3 * k, k == 2, k == 4);
        wait_until(r + 12);
        en = 1'b0;
        wait_until(r + 18);
        chk("reload_drain", q.size(), 0);

        // Illegal divisor clamps to 2 and flags
        load(1, 0, 1'b1, lp);
        chk("bad_cfg_err", int'(cfg_err), 1);
        for (int k = 1; k <= 4; k++)
            push(lp + 2 * k, k == 2, k == 4);
        wait_until(lp + 8);
        en = 1'b0;
        wait_until(lp + 12);
        chk("bad_drain", q.size(), 0);

        // Legal reload clears the flag; then pause en for 10 cycles
        load(5, 0, 1'b1, lp);
        chk("good_cfg_err", int'(cfg_err), 0);
        push(lp + 5, 1'b0, 1'b0);
        push(lp + 10, 1'b1, 1'b0);
        wait_until(lp + 12);
        en = 1'b0;
        wait_until(lp + 22);
        chk("pause_os", int'(os_tick), 0);
        en = 1'b1;
        for (int k = 1; k <= 4; k++)
            push(lp + 27 + 5 * (k - 1), k == 2, k == 4);
        wait_until(lp + 42);
        en = 1'b0;
        wait_until(lp + 50);
        chk("pause_drain", q.size(), 0);

        // Asynchronous reset while a strobe is high
        load(0, 3, 1'b1, lp);
        chk("zero_cfg_err", int'(cfg_err), 1);
        push(lp + 2, 1'b0, 1'b0);
        wait_until(lp + 2);
        #1;
        chk("pre_rst_os", int'(os_tick), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_os", int'(os_tick), 0);
        chk("arst_mid", int'(mid_tick), 0);
        chk("arst_baud", int'(baud_tick), 0);
        chk("arst_cfg_err", int'(cfg_err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        push(r + 651, 1'b0, 1'b0);
        push(r + 1302, 1'b1, 1'b0);
        wait_until(r + 1303);
        en = 1'b0;
        wait_until(r + 1310);
        chk("default_drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the integer divisor.
REQ-002 SHALL have parameter FRAC_W, default 4, width of the fractional divisor; fraction unit is 1/2^FRAC_W.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, oversample ticks per bit; legal range 2..256, even only.
REQ-004 SHALL have parameter DEF_DIV_INT, default 651, integer divisor loaded at reset (100 MHz / (9600*16)).
REQ-005 SHALL have parameter DEF_DIV_FRAC, default 0, fractional divisor loaded at reset.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port en  input  1  run enable; low holds the generator idle.
REQ-009 SHALL have port div_load  input  1  single-cycle pulse that captures div_int/div_frac.
REQ-010 SHALL have port div_int  input  DIV_W  requested integer divisor, in clk cycles per oversample tick.
REQ-011 SHALL have port div_frac  input  FRAC_W  requested fractional divisor.
REQ-012 SHALL have port os_tick  output  1  registered 1-cycle oversample strobe.
REQ-013 SHALL have port mid_tick  output  1  registered 1-cycle strobe at bit centre.
REQ-014 SHALL have port baud_tick  output  1  registered 1-cycle strobe at bit end.
REQ-015 SHALL have port cfg_err  output  1  sticky flag for an illegal divisor load.

Function
REQ-016 SHALL hold the active divisor pair (act_int, act_frac), a cycle counter cnt, a fraction accumulator acc[FRAC_W], a carry bit cy and an oversample counter os_cnt.
REQ-017 SHALL set the oversample period length L to act_int + cy clk cycles; cnt counts 0..L-1.
REQ-018 SHALL, in the cycle cnt==L-1 with en=1: assert os_tick next cycle; set cnt to 0; set {cy,acc} to acc + act_frac (FRAC_W+1-bit sum).
REQ-019 SHALL make the long-run mean period act_int + act_frac/2^FRAC_W cycles exactly, with no drift.
REQ-020 SHALL increment os_cnt on every os_tick event, wrapping from OVERSAMPLE-1 to 0.
REQ-021 SHALL assert mid_tick together with os_tick when the os_cnt value before the increment is OVERSAMPLE/2-1.
REQ-022 SHALL assert baud_tick together with os_tick when the os_cnt value before the increment is OVERSAMPLE-1.
REQ-023 SHALL make every strobe exactly 1 cycle wide; mid_tick and baud_tick never appear without os_tick.
REQ-024 SHALL, while en=0, clear cnt, acc, cy and os_cnt, drive all strobes 0, and retain act_int/act_frac.
REQ-025 SHALL, after en rises, emit the first os_tick as the registered output act_int cycles after the first enabled cycle.
REQ-026 SHALL, on div_load=1: capture the divisor into act_*; clear cnt, acc, cy and os_cnt; suppress all strobes that cycle. This applies regardless of en.
REQ-027 SHALL give div_load priority over a coincident period end; that tick is dropped.
REQ-028 SHALL, on a div_load with div_int<2: load act_int=2 and act_frac=div_frac, and set cfg_err.
REQ-029 SHALL clear cfg_err on a div_load with div_int>=2; otherwise cfg_err holds.
REQ-030 SHALL ignore div_int and div_frac when div_load=0.

Reset
REQ-031 SHALL, on rst_n low (asynchronous): act_int=DEF_DIV_INT, act_frac=DEF_DIV_FRAC, cnt=0, acc=0, cy=0, os_cnt=0, os_tick=mid_tick=baud_tick=0, cfg_err=0.
REQ-032 SHALL resume per REQ-025 on the first clk edge after rst_n deasserts, when en=1.
REQ-033 SHALL abort any period in progress on a mid-operation reset, with no residual strobe.

Verification
REQ-034 SHALL cover: OVERSAMPLE=4, load div_int=4/div_frac=0, en=1 -> os_tick every 4 cycles, mid_tick every 16 cycles (at the 2nd os_tick), baud_tick every 16 cycles (at the 4th os_tick).
REQ-035 SHALL cover: FRAC_W=4, div_int=4, div_frac=8 -> os_tick intervals 4,5,4,5,...; 32 os_ticks span exactly 144 cycles.
REQ-036 SHALL cover: div_int=6 running, div_load of div_int=3 coincident with a period end -> no tick that cycle; next os_tick 3 cycles later; os_cnt restarts at 0.
REQ-037 SHALL cover: div_load with div_int=1 -> cfg_err=1 and os_tick every 2 cycles; later load of div_int=5 -> cfg_err=0.
REQ-038 SHALL cover: en dropped mid-bit for 10 cycles then raised -> strobes 0 while low; first os_tick act_int cycles after re-enable; act_* unchanged.
REQ-039 SHALL cover: rst_n pulsed low asynchronously mid-period -> all outputs 0 immediately; DEF_DIV_INT=651 timing resumes after release.
